// File: rtl/period_timer_ctrl_pkg.sv
// period_timer_ctrl_pkg: shared state encodings and next-state rule for the period timer
//   ST_W      state register width
//   ST_*      IDLE=0, RUN=1, PAUSE=2, DONE=3
//   next_state  FSM transition with clear dominating start/pause
package period_timer_ctrl_pkg;
   localparam int ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
   localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;
   localparam logic [ST_W-1:0] ST_DONE  = 2'd3;
   // term is count==period; in RUN a one-shot terminal count parks in DONE,
   // an auto-reload one stays in RUN
   function automatic logic [ST_W-1:0] next_state(input logic [ST_W-1:0] st,
                                                  input logic start,
                                                  input logic pause,
                                                  input logic clear,
                                                  input logic term,
                                                  input logic reload);
      return clear ? ST_IDLE :
             (st == ST_IDLE || st == ST_DONE) ? (start ? ST_RUN : st) :
             st == ST_RUN ? (pause ? ST_PAUSE : (term && !reload) ? ST_DONE : ST_RUN) :
             (pause ? ST_PAUSE : ST_RUN);
   endfunction
endpackage

// File: rtl/period_timer_ctrl_ctr_en_reg.sv
// period_timer_ctrl_ctr_en_reg: Width-bit counter register with sync clear, enable and +1
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   clr_i    synchronous clear (beats enable)
//   en_i     increment enable
//   count_o  registered count
module period_timer_ctrl_ctr_en_reg #(
   parameter int Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) count_o <= '0;
      else if (en_i) count_o <= count_o + Width'(1);
   end
endmodule

// File: rtl/period_timer_ctrl.sv
// period_timer_ctrl: start/pause/resume/clear sequencer around a +1 counter with one-shot or auto-reload terminal count
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   start_i   start request (IDLE/DONE only)
//   pause_i   level pause (RUN<->PAUSE)
//   clear_i   abort to IDLE, count cleared
//   reload_i  latched on start: 1 auto-reload, 0 one-shot
//   period_i  terminal count, latched on start
//   count_o   current count
//   tick_o    one-cycle terminal-count pulse
//   done_o    one-shot finished
//   busy_o    RUN or PAUSE
module period_timer_ctrl
   import period_timer_ctrl_pkg::*;
#(
   parameter int Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             pause_i,
   input  logic             clear_i,
   input  logic             reload_i,
   input  logic [Width-1:0] period_i,
   output logic [Width-1:0] count_o,
   output logic             tick_o,
   output logic             done_o,
   output logic             busy_o
);
   logic [ST_W-1:0]  state_q;
   logic [Width-1:0] period_q;
   logic             reload_q;
   logic             tick_q;
   logic             term;
   logic             in_run;
   logic             load;
   logic             hit;
   logic             clr;
   logic             en;
   always_comb begin
      term   = count_o == period_q;
      in_run = state_q == ST_RUN;
      load   = !clear_i && start_i && (state_q == ST_IDLE || state_q == ST_DONE);
      hit    = in_run && !clear_i && !pause_i && term;
      // a start always begins from zero; an auto-reload terminal count wraps to zero
      clr    = clear_i || load || (hit && reload_q);
      en     = in_run && !clear_i && !pause_i && !term;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         period_q <= '0;
         reload_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q <= next_state(state_q, start_i, pause_i, clear_i, term, reload_q);
         tick_q  <= hit;
         if (load) begin
            period_q <= period_i;
            reload_q <= reload_i;
         end
      end
   end
   period_timer_ctrl_ctr_en_reg #(.Width(Width)) u_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clr),
      .en_i    (en),
      .count_o (count_o)
   );
   assign tick_o = tick_q;
   assign done_o = state_q == ST_DONE;
   assign busy_o = state_q == ST_RUN || state_q == ST_PAUSE;
endmodule

// File: tb/tb_period_timer_ctrl.sv
// tb_period_timer_ctrl: scoreboard bench for period_timer_ctrl against a behavioural model
module tb_period_timer_ctrl;
   logic       clk = 1'b0;
   logic       rst_i = 1'b1, start_i = 1'b0, pause_i = 1'b0, clear_i = 1'b0, reload_i = 1'b0;
   logic [3:0] period_i = '0;
   logic [3:0] count_o;
   logic       tick_o, done_o, busy_o;
   always #5 clk = ~clk;
   period_timer_ctrl #(.Width(4)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .pause_i  (pause_i),
      .clear_i  (clear_i),
      .reload_i (reload_i),
      .period_i (period_i),
      .count_o  (count_o),
      .tick_o   (tick_o),
      .done_o   (done_o),
      .busy_o   (busy_o)
   );
   typedef enum {IDLE, RUNNING, PAUSED, FINISHED} mode_t;
   typedef struct {
      int count;
      bit tick;
      bit done;
      bit busy;
   } exp_t;
   exp_t  exp_q[$];
   int    passed = 0, total = 0, ticks = 0, snap = 0;
   mode_t mode = IDLE;
   int    m_count = 0, m_period = 0;
   bit    m_reload = 0, m_tick = 0;
   task automatic chk(string n, int got, int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s: got %0d want %0d at %0t", n, got, want, $time);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (tick_o) ticks++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("count", int'(count_o), e.count);
         chk("tick", int'(tick_o), int'(e.tick));
         chk("done", int'(done_o), int'(e.done));
         chk("busy", int'(busy_o), int'(e.busy));
      end
   end
   task automatic cyc(bit rs, bit st, bit ps, bit cl, bit rl, logic [3:0] pd);
      rst_i = rs; start_i = st; pause_i = ps; clear_i = cl; reload_i = rl; period_i = pd;
      @(posedge clk);
      m_tick = 0;
      if (rs) begin
         mode = IDLE; m_count = 0; m_period = 0; m_reload = 0;
      end else if (cl) begin
         mode = IDLE; m_count = 0;
      end else begin
         case (mode)
            IDLE, FINISHED: if (st) begin
               mode = RUNNING; m_period = int'(pd); m_reload = rl; m_count = 0;
            end
            RUNNING: if (ps) mode = PAUSED;
               else if (m_count == m_period) begin
                  m_tick = 1;
                  if (m_reload) m_count = 0;
                  else mode = FINISHED;
               end else m_count = m_count + 1;
            PAUSED: if (!ps) mode = RUNNING;
            default: mode = IDLE;
         endcase
      end
      exp_q.push_back('{m_count, m_tick, mode == FINISHED, mode == RUNNING || mode == PAUSED});
      #1;
   endtask
   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 4'd0);
   endtask
   task automatic settle();
      @(negedge clk);
      #1;
   endtask
   initial begin
      cyc(1, 1, 0, 0, 0, 4'd0);
      cyc(1, 1, 0, 0, 0, 4'd0);
      cyc(0, 1, 0, 0, 0, 4'd3);
      idle(6);
      cyc(0, 0, 0, 1, 0, 4'd0);
      settle(); snap = ticks;
      cyc(0, 1, 0, 0, 1, 4'd2);
      idle(9);
      settle(); chk("reload2_ticks", ticks - snap, 3);
      cyc(0, 0, 0, 1, 0, 4'd0);
      cyc(0, 1, 0, 0, 1, 4'd5);
      idle(1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 4'd0);
      idle(2);
      cyc(0, 0, 0, 1, 0, 4'd0);
      cyc(0, 1, 0, 0, 0, 4'd7);
      idle(2);
      cyc(0, 0, 1, 1, 0, 4'd0);
      cyc(0, 1, 0, 0, 0, 4'd1);
      idle(4);
      cyc(0, 1, 0, 1, 1, 4'd9);
      idle(1);
      cyc(0, 1, 0, 0, 0, 4'd7);
      idle(2);
      cyc(1, 0, 0, 0, 0, 4'd0);
      idle(1);
      settle(); snap = ticks;
      cyc(0, 1, 0, 0, 1, 4'd0);
      idle(5);
      settle(); chk("period0_ticks", ticks - snap, 5);
      cyc(0, 0, 0, 1, 0, 4'd0);
      settle(); snap = ticks;
      cyc(0, 1, 0, 0, 1, 4'd15);
      idle(34);
      settle(); chk("period15_ticks", ticks - snap, 2);
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)));
      idle(1);
      settle();
      chk("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
